// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared defaults, saturation limit and FSM encoding for the requant output stage
package npu_pkg;

  // Default lane geometry; the top and lane modules take these as parameter defaults.
  localparam int ARRAY_N_DEF   = 16;
  localparam int IN_WIDTH_DEF  = 32;
  localparam int OUT_WIDTH_DEF = 8;
  localparam int SHIFT_W_DEF   = 5;
  localparam int CNT_W_DEF     = 16;

  // Largest unsigned value representable in a default-width output lane.
  localparam int OUT_MAX = (1 << OUT_WIDTH_DEF) - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - single-lane clamp, rounding right-shift and unsigned saturation
import npu_pkg::*;

module requant_lane #(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int SHIFT_W   = SHIFT_W_DEF,
  parameter int SAT_MAX   = OUT_MAX
) (
  input  logic [IN_WIDTH-1:0]  lane_in,
  input  logic [SHIFT_W-1:0]   shift,
  output logic [OUT_WIDTH-1:0] lane_out
);

  // One extra bit of headroom so the half-LSB rounding add never wraps.
  localparam logic [IN_WIDTH:0] SAT_EXT = (IN_WIDTH + 1)'(SAT_MAX);

  logic [IN_WIDTH:0] ext;
  logic [IN_WIDTH:0] rnd;
  logic [IN_WIDTH:0] sum;
  logic [IN_WIDTH:0] shifted;

  // Negative inputs clamp to zero; otherwise round-half-up, shift, then saturate.
  always_comb begin
    ext = {1'b0, lane_in};
    rnd = '0;
    if (shift != '0) begin
      rnd = {{IN_WIDTH{1'b0}}, 1'b1} << (shift - SHIFT_W'(1));
    end
    sum     = ext + rnd;
    shifted = sum >> shift;
    if (lane_in[IN_WIDTH-1]) begin
      lane_out = '0;
    end else if (shifted > SAT_EXT) begin
      lane_out = SAT_EXT[OUT_WIDTH-1:0];
    end else begin
      lane_out = shifted[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/requant_output_stage.sv
// rtl/requant_output_stage.sv - per-layer requantization with valid/ready output register and done pulse
import npu_pkg::*;

module requant_output_stage #(
  parameter int ARRAY_N   = ARRAY_N_DEF,
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int SHIFT_W   = SHIFT_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [SHIFT_W-1:0]            cfg_shift,
  input  logic [CNT_W-1:0]              cfg_count,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ARRAY_N*IN_WIDTH-1:0]   data_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ARRAY_N*OUT_WIDTH-1:0]  data_out,
  output logic                          busy,
  output logic                          done
);

  state_e                         state_q, state_d;
  logic [SHIFT_W-1:0]             shift_q, shift_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [CNT_W-1:0]               acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]               emit_cnt_q, emit_cnt_d;
  logic                           out_valid_q, out_valid_d;
  logic [ARRAY_N*OUT_WIDTH-1:0]   data_out_q, data_out_d;
  logic [ARRAY_N*OUT_WIDTH-1:0]   lanes_rq;
  logic                           accept;
  logic                           out_hs;

  for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
    requant_lane #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .SHIFT_W  (SHIFT_W),
      .SAT_MAX  ((1 << OUT_WIDTH) - 1)
    ) u_lane (
      .lane_in (data_in[IN_WIDTH*i +: IN_WIDTH]),
      .shift   (shift_q),
      .lane_out(lanes_rq[OUT_WIDTH*i +: OUT_WIDTH])
    );
  end

  // Accept only while the layer still owes vectors and the output slot is free or draining.
  assign in_ready  = (state_q == ST_RUN) && (acc_cnt_q < count_q) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_FIN);

  // Next-state, counter and output-register update.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    acc_cnt_d   = acc_cnt_q;
    emit_cnt_d  = emit_cnt_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d    = cfg_shift;
          count_d    = cfg_count;
          acc_cnt_d  = '0;
          emit_cnt_d = '0;
          state_d    = (cfg_count == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
        if (out_hs) begin
          emit_cnt_d = emit_cnt_q + CNT_W'(1);
          if (emit_cnt_q + CNT_W'(1) == count_q) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      out_valid_d = 1'b1;
      data_out_d  = lanes_rq;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any in-flight vector and the layer config.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      acc_cnt_q   <= '0;
      emit_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      acc_cnt_q   <= acc_cnt_d;
      emit_cnt_q  <= emit_cnt_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end

endmodule

// File: tb/tb_requant_output_stage.sv
// tb/tb_requant_output_stage.sv - self-checking bench for requant_output_stage
module tb_requant_output_stage;

  localparam int N  = 16;
  localparam int IW = 32;
  localparam int OW = 8;
  localparam int SW = 5;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [SW-1:0]   cfg_shift = '0;
  logic [CW-1:0]   cfg_count = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*IW-1:0] data_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [N*OW-1:0] data_out;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  // Reference-model layer state.
  logic            run_m;
  int              acc_m, emit_m, count_m, shift_m;
  logic [N*OW-1:0] exp_q[$];
  logic [N*OW-1:0] last_out;
  int              cycles, ov_cycles;
  int              out_policy, iv_policy, stall_left, inj_at;
  logic            use_fixed;
  logic [N*IW-1:0] fixed_vec;

  requant_output_stage dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cfg_shift(cfg_shift),
    .cfg_count(cfg_count),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_lane(input logic [31:0] raw, input int s);
    longint x, r;
    x = longint'($signed(raw));
    if (x < 0) return 8'h00;
    if (s == 0) r = x;
    else r = (x + (longint'(1) << (s - 1))) / (longint'(1) << s);
    if (r > 255) return 8'hFF;
    return r[7:0];
  endfunction

  function automatic logic [N*OW-1:0] ref_vec(input logic [N*IW-1:0] v, input int s);
    logic [N*OW-1:0] o;
    for (int i = 0; i < N; i++) o[i*OW +: OW] = ref_lane(v[i*IW +: IW], s);
    return o;
  endfunction

  function automatic logic [N*IW-1:0] rand_vec(input int s);
    logic [N*IW-1:0] v;
    logic [31:0]     lim;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(3, 0))
        0: v[i*IW +: IW] = $urandom;
        1: begin
          lim = (s >= 22) ? 32'h7FFF_FFFF : ((32'd1 << (s + 9)) - 32'd1);
          v[i*IW +: IW] = $urandom_range(lim, 0);
        end
        2: v[i*IW +: IW] = $urandom_range(1023, 0);
        default: v[i*IW +: IW] = ($urandom_range(1, 0) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      endcase
    end
    return v;
  endfunction

  task automatic do_start(input int s, input int c);
    @(negedge clk);
    cfg_shift = SW'(s);
    cfg_count = CW'(c);
    start     = 1'b1;
    shift_m = s; count_m = c; acc_m = 0; emit_m = 0;
    exp_q.delete();
    run_m = (c != 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_layer();
    int              cyc;
    logic            need_new, exp_ir, acc;
    logic [N*IW-1:0] cur;
    cyc = 0; need_new = 1'b1; cur = '0; ov_cycles = 0;
    while (run_m && cyc < 1000) begin
      if (need_new) cur = use_fixed ? fixed_vec : rand_vec(shift_m);
      data_in  = cur;
      in_valid = (iv_policy == 1) ? 1'b1 : ($urandom_range(3, 0) != 0);
      case (out_policy)
        1: out_ready = 1'b1;
        2: if (exp_q.size() != 0 && emit_m == 1 && stall_left > 0) begin
             out_ready = 1'b0;
             stall_left--;
           end else out_ready = 1'b1;
        default: out_ready = ($urandom_range(2, 0) != 0);
      endcase
      start = (cyc == inj_at);
      if (cyc == inj_at) begin
        cfg_count = CW'(2);
        cfg_shift = SW'($urandom_range(31, 0));
      end
      #1;
      exp_ir = run_m && (acc_m < count_m) && (exp_q.size() == 0 || out_ready);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("data_out", data_out, exp_q[0]);
      chk("in_ready", in_ready, exp_ir);
      chk("busy_run", busy, 1'b1);
      chk("done_run", done, 1'b0);
      if (exp_q.size() != 0) begin
        ov_cycles++;
        if (out_ready) begin
          last_out = data_out;
          void'(exp_q.pop_front());
          emit_m++;
          if (emit_m == count_m) run_m = 1'b0;
        end
      end
      acc = in_valid && exp_ir;
      if (acc) begin
        exp_q.push_back(ref_vec(cur, shift_m));
        acc_m++;
      end
      need_new = acc || !in_valid;
      cyc++;
      @(negedge clk);
    end
    cycles = cyc;
    chk("layer_timeout", run_m, 1'b0);
    start = 1'b0; in_valid = 1'b0;
    #1;
    chk("done_pulse", done, 1'b1);
    chk("fin_out_valid", out_valid, 1'b0);
    chk("fin_busy", busy, 1'b0);
    chk("fin_in_ready", in_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("done_clear", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    inj_at = -1; use_fixed = 1'b0; fixed_vec = '0;
    out_policy = 1; iv_policy = 1; stall_left = 0; last_out = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data_out", data_out, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Basic rounding: 248 >> 4 rounds 15.5 up to 16.
    use_fixed = 1'b1;
    fixed_vec = '0; fixed_vec[31:0] = 32'h0000_00F8;
    do_start(4, 1); run_layer();
    chk("basic_lane0", last_out[7:0], 8'h10);
    chk("basic_latency", cycles, 2);

    // Saturation and negative clamp with no shift.
    fixed_vec = '0; fixed_vec[31:0] = 32'd300; fixed_vec[63:32] = 32'hFFFF_FFF0;
    do_start(0, 1); run_layer();
    chk("sat_300", last_out[7:0], 8'hFF);
    chk("neg_clamp", last_out[15:8], 8'h00);

    fixed_vec = '0; fixed_vec[31:0] = 32'h7FFF_FFFF; fixed_vec[63:32] = 32'h0000_7F80;
    do_start(8, 1); run_layer();
    chk("sat_max", last_out[7:0], 8'hFF);
    chk("round_s8", last_out[15:8], 8'h80);

    fixed_vec = '0; fixed_vec[31:0] = 32'h4000_0000; fixed_vec[63:32] = 32'h3FFF_FFFF;
    do_start(31, 1); run_layer();
    chk("s31_round_up", last_out[7:0], 8'h01);
    chk("s31_round_dn", last_out[15:8], 8'h00);
    use_fixed = 1'b0;

    // Backpressure on vector 2 with a start pulse ignored mid-layer.
    out_policy = 2; stall_left = 3; inj_at = 2;
    do_start(3, 4); run_layer();
    chk("stall_used", stall_left, 0);
    inj_at = -1;

    // Full throughput.
    out_policy = 1; iv_policy = 1;
    do_start(5, 8); run_layer();
    chk("thru_cycles", cycles, 9);
    chk("thru_outputs", ov_cycles, 8);

    // Empty layer.
    do_start(7, 0); run_layer();
    chk("empty_outputs", ov_cycles, 0);

    // Randomized layers.
    out_policy = 0; iv_policy = 0;
    repeat (6) begin
      do_start($urandom_range(31, 0), $urandom_range(10, 1));
      run_layer();
    end

    // Reset with a vector held in the output register.
    do_start(2, 5);
    in_valid = 1'b1; out_ready = 1'b0; data_in = rand_vec(2);
    #1;
    chk("pre_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #1;
    chk("pre_rst_out_valid", out_valid, 1'b1);
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_data_out", data_out, '0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    do_start($urandom_range(31, 0), 6);
    run_layer();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
